arty_reset_ctrl: RTL and testbench
==================================

# arty_reset_ctrl

Reset sequencer between the MMCM clock stage and the Cortex-M0 subsystem. It runs on the generated 50 MHz clock and consumes the MMCM `locked` flag, the board reset pushbutton, and the core's SYSRESETREQ/LOCKUP outputs. It produces a power-on reset for debug and always-on logic and a system reset for the core and peripherals. It also keeps a cause register for software.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive cycles `locked` must stay high before power-on reset releases (≥2).
- `HOLD_CYCLES`, default 16: minimum cycles `sys_resetn` stays low per reset (≥1).
- `BTN_DEBOUNCE_CYCLES`, default 65536: cycles the synchronized button must be stable before its debounced level changes (≥1).
- `CNT_W`, default 17: counter width; must hold max(LOCK_STABLE_CYCLES, HOLD_CYCLES, BTN_DEBOUNCE_CYCLES).

Ports:
- `clk_50m` in 1: system clock (the MMCM output).
- `reset` in 1: reset, synchronous and active-high.
- `locked` in 1: MMCM lock, asynchronous; 2-flop synchronized internally to `locked_sync`.
- `btn_rst` in 1: pushbutton, active-high, asynchronous; 2-flop synchronized then debounced to `btn_db`.
- `sysresetreq` in 1: core reset request, synchronous to `clk_50m`.
- `lockup` in 1: core lockup, synchronous to `clk_50m`.
- `lockup_reset_en` in 1: static enable; lockup triggers a system reset.
- `por_resetn` out 1: active-low power-on reset.
- `sys_resetn` out 1: active-low system reset.
- `reset_cause` out 4: one-hot cause of the most recent reset. [0] lock/POR, [1] button, [2] sysresetreq, [3] lockup.
- `rst_state` out 2: current FSM state, for debug.

## Operation
- All outputs are registered.
- On `reset`, the following values appear on the next cycle:
  - state WAIT_LOCK (0), all counters 0, sync flops 0, `btn_db`=0
  - `por_resetn`=0, `sys_resetn`=0, `reset_cause`=4'b0001
- This applies from any state, mid-count included.
- FSM states:
  - **WAIT_LOCK (0):** both resets low. When `locked_sync`=1, go to STABLE with the counter cleared.
  - **STABLE (1):** the counter increments each cycle while `locked_sync`=1.
    - If `locked_sync`=0, go back to WAIT_LOCK and clear the counter.
    - When counter==LOCK_STABLE_CYCLES-1, go to HOLD, set `por_resetn`=1 and clear the counter.
  - **HOLD (2):** `sys_resetn`=0 and the counter increments.
    - If `btn_db`=1, the counter is held at 0, so reset is extended while the button is held.
    - When counter==HOLD_CYCLES-1 and `btn_db`=0, go to RUN and set `sys_resetn`=1.
    - `sysresetreq` and `lockup` are ignored in HOLD.
  - **RUN (3):** `sys_resetn`=1. Reset events are evaluated each cycle in priority order:
    1. `locked_sync`=0: go to WAIT_LOCK with `por_resetn`=0, `sys_resetn`=0, cause 0001.
    2. `btn_db`=1: go to HOLD, cause 0010.
    3. `sysresetreq`=1: go to HOLD, cause 0100.
    4. `lockup`=1 and `lockup_reset_en`=1: go to HOLD, cause 1000.
    - Each transition to HOLD drives `sys_resetn`=0 and clears the counter.
- Loss of lock (`locked_sync`=0) in HOLD or RUN always goes to WAIT_LOCK, drops both resets and sets cause 0001.
- Only lock/POR events deassert `por_resetn`. The button, sysresetreq and lockup leave it high.
- When several events coincide, only the highest-priority cause bit is recorded. `reset_cause` is replaced only on entry to a reset and is stable otherwise.
- Debounce:
  - A separate counter clears whenever `btn_sync`==`btn_db`.
  - Otherwise it increments, and `btn_db` toggles when the count reaches BTN_DEBOUNCE_CYCLES-1 (the counter then clears).
  - Glitches shorter than BTN_DEBOUNCE_CYCLES never reach `btn_db`.
- With `lockup_reset_en`=0, `lockup` has no effect.

## Timing
- `locked` rising before edge k gives `locked_sync`=1 after edge k+1, and STABLE after edge k+2.
  - `por_resetn` rises after edge k+LOCK_STABLE_CYCLES+2.
  - `sys_resetn` rises after edge k+LOCK_STABLE_CYCLES+HOLD_CYCLES+2.
- `locked` falling before edge k in RUN: both resets low after edge k+2.
- `sysresetreq` high at edge j in RUN: `sys_resetn`=0 after edge j and back to 1 after edge j+HOLD_CYCLES. A 1-cycle pulse is sufficient.
- `btn_rst` rising before edge k and held: `btn_db`=1 after edge k+BTN_DEBOUNCE_CYCLES+1, and `sys_resetn`=0 after edge k+BTN_DEBOUNCE_CYCLES+2.
- The system reset is never shorter than HOLD_CYCLES cycles.

## Test plan
Parameters for all scenarios: LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4, BTN_DEBOUNCE_CYCLES=5.

1. Release `reset`, then raise `locked` before edge k → `por_resetn` 1 at k+10, `sys_resetn` 1 at k+14, `rst_state` 3, `reset_cause`=0001.
2. In STABLE, drop `locked` for 1 cycle after 5 stable cycles → state returns to 0, counter restarts, `por_resetn` stays 0. Full lock then releases per scenario 1 timing measured from the new rise.
3. In RUN, 1-cycle `sysresetreq` at edge j → `sys_resetn` low for exactly 4 cycles (j+1..j+4 sampled low), `por_resetn` stays 1, `reset_cause`=0100.
4. In RUN:
   - 3-cycle `btn_rst` glitch → no reset.
   - 20-cycle press → `sys_resetn` low from k+7 until 4 cycles after `btn_db` falls, `reset_cause`=0010.
5. In RUN:
   - `lockup`=1 with `lockup_reset_en`=0 → no effect.
   - Set `lockup_reset_en`=1 while `sysresetreq` is asserted the same cycle → cause 0100 only.
   - Then `lockup` alone → cause 1000.
6. Assert `reset` mid-HOLD and mid-debounce → next cycle all outputs at reset values (`rst_state` 0, cause 0001). Drop `locked` in RUN → both resets 0 two cycles later.

Source files
------------

// File: rtl/arty_reset_ctrl.sv
// arty_reset_ctrl
//
// Reset sequencer between the MMCM clock stage and the Cortex-M0 subsystem.
// It waits for a stable MMCM lock, then releases the power-on reset. After a
// minimum hold time it releases the system reset. While running, it re-enters
// reset on loss of lock, on a debounced button press, on SYSRESETREQ, or on
// LOCKUP (when enabled). The cause of the most recent reset is kept for software.
//
// Ports:
//   clk_50m          in   system clock (MMCM output)
//   reset            in   synchronous active-high reset
//   locked           in   MMCM lock flag (asynchronous, synchronized here)
//   btn_rst          in   reset pushbutton, active-high (asynchronous, debounced here)
//   sysresetreq      in   core reset request (clk_50m domain)
//   lockup           in   core lockup indication (clk_50m domain)
//   lockup_reset_en  in   static enable: lockup triggers a system reset
//   por_resetn       out  active-low power-on reset (debug / always-on logic)
//   sys_resetn       out  active-low system reset (core and peripherals)
//   reset_cause      out  one-hot cause: [0] lock/POR [1] button [2] sysresetreq [3] lockup
//   rst_state        out  current FSM state, for debug

module arty_reset_ctrl #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned HOLD_CYCLES         = 16,
    parameter int unsigned BTN_DEBOUNCE_CYCLES = 65536,
    parameter int unsigned CNT_W               = 17
) (
    input  logic       clk_50m,
    input  logic       reset,
    input  logic       locked,
    input  logic       btn_rst,
    input  logic       sysresetreq,
    input  logic       lockup,
    input  logic       lockup_reset_en,
    output logic       por_resetn,
    output logic       sys_resetn,
    output logic [3:0] reset_cause,
    output logic [1:0] rst_state
);

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StStable   = 2'd1,
        StHold     = 2'd2,
        StRun      = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DbLast   = CNT_W'(BTN_DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    localparam logic [3:0] CauseLock    = 4'b0001;
    localparam logic [3:0] CauseButton  = 4'b0010;
    localparam logic [3:0] CauseSysReq  = 4'b0100;
    localparam logic [3:0] CauseLockup  = 4'b1000;

    // Synchronizers
    logic locked_meta_q, locked_sync_q;
    logic btn_meta_q, btn_sync_q;

    // Debouncer
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             btn_db_q, btn_db_d;

    // Sequencer
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             por_resetn_q, por_resetn_d;
    logic             sys_resetn_q, sys_resetn_d;
    logic [3:0]       cause_q, cause_d;

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            locked_meta_q <= 1'b0;
            locked_sync_q <= 1'b0;
            btn_meta_q    <= 1'b0;
            btn_sync_q    <= 1'b0;
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            state_q       <= StWaitLock;
            cnt_q         <= '0;
            por_resetn_q  <= 1'b0;
            sys_resetn_q  <= 1'b0;
            cause_q       <= CauseLock;
        end else begin
            locked_meta_q <= locked;
            locked_sync_q <= locked_meta_q;
            btn_meta_q    <= btn_rst;
            btn_sync_q    <= btn_meta_q;
            db_cnt_q      <= db_cnt_d;
            btn_db_q      <= btn_db_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            por_resetn_q  <= por_resetn_d;
            sys_resetn_q  <= sys_resetn_d;
            cause_q       <= cause_d;
        end
    end

    // Debounce: the level only flips after the synchronized input has
    // disagreed with it for BTN_DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        db_cnt_d = db_cnt_q;
        btn_db_d = btn_db_q;
        if (btn_sync_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            btn_db_d = ~btn_db_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + CntOne;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        por_resetn_d = por_resetn_q;
        sys_resetn_d = sys_resetn_q;
        cause_d      = cause_q;

        unique case (state_q)
            StWaitLock: begin
                por_resetn_d = 1'b0;
                sys_resetn_d = 1'b0;
                cnt_d        = '0;
                if (locked_sync_q) begin
                    state_d = StStable;
                end
            end

            StStable: begin
                if (!locked_sync_q) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == LockLast) begin
                    state_d      = StHold;
                    por_resetn_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StHold: begin
                sys_resetn_d = 1'b0;
                if (!locked_sync_q) begin
                    state_d      = StWaitLock;
                    por_resetn_d = 1'b0;
                    cause_d      = CauseLock;
                    cnt_d        = '0;
                end else if (btn_db_q) begin
                    // Keep restarting the hold while the button is down.
                    cnt_d = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d      = StRun;
                    sys_resetn_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StRun: begin
                // Priority: lock loss, button, sysresetreq, lockup.
                if (!locked_sync_q) begin
                    state_d      = StWaitLock;
                    por_resetn_d = 1'b0;
                    sys_resetn_d = 1'b0;
                    cause_d      = CauseLock;
                    cnt_d        = '0;
                end else if (btn_db_q) begin
                    state_d      = StHold;
                    sys_resetn_d = 1'b0;
                    cause_d      = CauseButton;
                    cnt_d        = '0;
                end else if (sysresetreq) begin
                    state_d      = StHold;
                    sys_resetn_d = 1'b0;
                    cause_d      = CauseSysReq;
                    cnt_d        = '0;
                end else if (lockup && lockup_reset_en) begin
                    state_d      = StHold;
                    sys_resetn_d = 1'b0;
                    cause_d      = CauseLockup;
                    cnt_d        = '0;
                end
            end
        endcase
    end

    assign por_resetn  = por_resetn_q;
    assign sys_resetn  = sys_resetn_q;
    assign reset_cause = cause_q;
    assign rst_state   = state_q;

endmodule

// File: tb/tb_arty_reset_ctrl.sv
// Self-checking bench for arty_reset_ctrl with small timing parameters.
// Directed scenarios use expectations derived from the edge-count timing
// rules; a randomized phase in RUN is scored against a countdown model of
// the minimum hold window and the cause priority.

module tb_arty_reset_ctrl;

    localparam int unsigned L = 8;
    localparam int unsigned H = 4;
    localparam int unsigned B = 5;

    logic       clk_50m = 1'b0;
    logic       reset;
    logic       locked;
    logic       btn_rst;
    logic       sysresetreq;
    logic       lockup;
    logic       lockup_reset_en;
    logic       por_resetn;
    logic       sys_resetn;
    logic [3:0] reset_cause;
    logic [1:0] rst_state;

    int n_total = 0;
    int n_pass  = 0;

    arty_reset_ctrl #(
        .LOCK_STABLE_CYCLES  (L),
        .HOLD_CYCLES         (H),
        .BTN_DEBOUNCE_CYCLES (B),
        .CNT_W               (17)
    ) dut (
        .clk_50m         (clk_50m),
        .reset           (reset),
        .locked          (locked),
        .btn_rst         (btn_rst),
        .sysresetreq     (sysresetreq),
        .lockup          (lockup),
        .lockup_reset_en (lockup_reset_en),
        .por_resetn      (por_resetn),
        .sys_resetn      (sys_resetn),
        .reset_cause     (reset_cause),
        .rst_state       (rst_state)
    );

    always #5 clk_50m = ~clk_50m;

    // Advance one active edge and settle before sampling.
    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic p, input logic s,
                             input logic [3:0] c, input logic [1:0] st);
        check({tag, "/por"},   8'(por_resetn),  8'(p));
        check({tag, "/sys"},   8'(sys_resetn),  8'(s));
        check({tag, "/cause"}, 8'(reset_cause), 8'(c));
        check({tag, "/state"}, 8'(rst_state),   8'(st));
    endtask

    initial begin
        int         low_left;
        logic [3:0] exp_cause;
        logic       sreq_r, lk_r, en_r;
        logic       exp_sys;

        reset           = 1'b1;
        locked          = 1'b0;
        btn_rst         = 1'b0;
        sysresetreq     = 1'b0;
        lockup          = 1'b0;
        lockup_reset_en = 1'b0;
        ticks(3);
        check_all("reset", 1'b0, 1'b0, 4'b0001, 2'd0);
        reset = 1'b0;
        ticks(2);
        check_all("idle", 1'b0, 1'b0, 4'b0001, 2'd0);

        // Lock rises before edge k; STABLE after k+2.
        locked = 1'b1;
        ticks(3);
        check("s2_stable_entry", 8'(rst_state), 8'd1);
        // Five stable cycles, then a one-cycle drop.
        ticks(5);
        locked = 1'b0;
        tick();
        locked = 1'b1;   // new rise before edge k'
        ticks(2);        // edges k', k'+1
        check_all("s2_dropped", 1'b0, 1'b0, 4'b0001, 2'd0);
        tick();          // k'+2
        check("s1_stable", 8'(rst_state), 8'd1);
        ticks(L - 1);    // k'+L+1
        check("s1_por_still_low", 8'(por_resetn), 8'd0);
        tick();          // k'+L+2
        check_all("s1_por_rise", 1'b1, 1'b0, 4'b0001, 2'd2);
        ticks(H - 1);    // k'+L+H+1
        check("s1_sys_still_low", 8'(sys_resetn), 8'd0);
        tick();          // k'+L+H+2
        check_all("s1_run", 1'b1, 1'b1, 4'b0001, 2'd3);

        // One-cycle sysresetreq.
        sysresetreq = 1'b1;
        tick();
        sysresetreq = 1'b0;
        check_all("s3_enter", 1'b1, 1'b0, 4'b0100, 2'd2);
        for (int i = 1; i < int'(H); i++) begin
            tick();
            check("s3_hold_low", 8'(sys_resetn), 8'd0);
        end
        tick();
        check_all("s3_release", 1'b1, 1'b1, 4'b0100, 2'd3);

        // Short button glitch is filtered.
        btn_rst = 1'b1;
        ticks(3);
        btn_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s4_glitch_sys", 8'(sys_resetn), 8'd1);
        end

        // 20-cycle press starting before edge k; tick i lands on edge k+i-1.
        btn_rst = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (i == 20) btn_rst = 1'b0;
            exp_sys = !(i >= int'(B) + 3 && i <= 20 + int'(B) + int'(H) + 1);
            check("s4_press_sys", 8'(sys_resetn), 8'(exp_sys));
        end
        check_all("s4_after", 1'b1, 1'b1, 4'b0010, 2'd3);

        // Lockup disabled, then coincident with sysresetreq, then alone.
        lockup_reset_en = 1'b0;
        lockup          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s5_lockup_off", 8'(sys_resetn), 8'd1);
        end
        lockup_reset_en = 1'b1;
        sysresetreq     = 1'b1;
        tick();
        sysresetreq = 1'b0;
        lockup      = 1'b0;
        check_all("s5_coincide", 1'b1, 1'b0, 4'b0100, 2'd2);
        ticks(H);
        check_all("s5_back", 1'b1, 1'b1, 4'b0100, 2'd3);
        lockup = 1'b1;
        tick();
        lockup = 1'b0;
        check_all("s5_lockup", 1'b1, 1'b0, 4'b1000, 2'd2);
        ticks(H);
        check("s5_lockup_release", 8'(sys_resetn), 8'd1);

        // Random core requests in RUN; low_left counts remaining reset cycles.
        low_left  = 0;
        exp_cause = 4'b1000;
        for (int n = 0; n < 300; n++) begin
            sreq_r          = ($urandom_range(7) == 0);
            lk_r            = ($urandom_range(5) == 0);
            en_r            = 1'($urandom_range(1));
            sysresetreq     = sreq_r;
            lockup          = lk_r;
            lockup_reset_en = en_r;
            tick();
            if (low_left > 0) begin
                low_left--;
            end else if (sreq_r) begin
                low_left  = int'(H);
                exp_cause = 4'b0100;
            end else if (lk_r && en_r) begin
                low_left  = int'(H);
                exp_cause = 4'b1000;
            end
            check("rnd_sys", 8'(sys_resetn), 8'(low_left == 0));
            check("rnd_cause", 8'(reset_cause), 8'(exp_cause));
            check("rnd_por", 8'(por_resetn), 8'd1);
        end
        sysresetreq     = 1'b0;
        lockup          = 1'b0;
        lockup_reset_en = 1'b0;
        ticks(H);
        check("rnd_settle", 8'(rst_state), 8'd3);

        // Reset mid-HOLD and mid-debounce.
        btn_rst = 1'b1;
        ticks(3);
        sysresetreq = 1'b1;
        tick();
        sysresetreq = 1'b0;
        check("s6_in_hold", 8'(rst_state), 8'd2);
        reset   = 1'b1;
        btn_rst = 1'b0;
        tick();
        check_all("s6_reset", 1'b0, 1'b0, 4'b0001, 2'd0);
        tick();
        reset = 1'b0;
        // locked already high: first non-reset edge is edge k.
        for (int i = 1; i <= int'(L + H) + 3; i++) begin
            tick();
            if (i == int'(L) + 2) check("s6_por_low", 8'(por_resetn), 8'd0);
            if (i == int'(L) + 3) check("s6_por_rise", 8'(por_resetn), 8'd1);
        end
        check_all("s6_relock", 1'b1, 1'b1, 4'b0001, 2'd3);

        // Lock loss in RUN: both resets low after edge k+2.
        locked = 1'b0;
        tick();
        check("s6_loss_k", 8'(sys_resetn), 8'd1);
        tick();
        check("s6_loss_k1", 8'(por_resetn), 8'd1);
        tick();
        check_all("s6_lock_loss", 1'b0, 1'b0, 4'b0001, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
